// File: rtl/window3x3_linebuf.sv
// rtl/window3x3_linebuf.sv - two-line buffer that assembles 3x3 pixel windows from a raster stream
// Windows are registered one cycle after the pixel that completes them; edge windows are never produced.
module window3x3_linebuf #(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tstart,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              win_valid,
  output logic [DATA_W-1:0] win_data [3][3],
  output logic              busy,
  output logic              frame_done
);

  localparam int CW = 11;
  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] ROW_LAST = CW'(IMG_H - 1);
  localparam logic [CW-1:0] TWO      = CW'(2);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [CW-1:0]     row_q, row_d, col_q, col_d;
  logic              win_valid_q, win_valid_d;
  logic              frame_done_q, frame_done_d;
  logic [DATA_W-1:0] win_q [3][3];
  logic [DATA_W-1:0] win_d [3][3];
  logic [DATA_W-1:0] sr_q [3][2];
  logic [DATA_W-1:0] sr_d [3][2];
  logic [DATA_W-1:0] lb0_mem [IMG_W];
  logic [DATA_W-1:0] lb1_mem [IMG_W];

  logic              accept;
  logic              is_win;
  logic              is_last;
  logic [CW-1:0]     acc_row, acc_col;
  logic [AW-1:0]     idx;
  logic [DATA_W-1:0] new_col [3];

  always_comb begin
    accept  = in_valid && (tstart || (state_q == S_RUN));
    // tstart forces the accepted pixel to (0,0) regardless of where the counters were
    acc_row = tstart ? '0 : row_q;
    acc_col = tstart ? '0 : col_q;
    idx     = acc_col[AW-1:0];
    new_col[0] = lb1_mem[idx];
    new_col[1] = lb0_mem[idx];
    new_col[2] = in_data;
    is_win  = accept && (acc_row >= TWO) && (acc_col >= TWO);
    is_last = accept && (acc_row == ROW_LAST) && (acc_col == COL_LAST);

    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    sr_d         = sr_q;
    win_d        = win_q;
    win_valid_d  = is_win;
    frame_done_d = is_last;

    if (tstart) begin
      state_d = S_RUN;
      row_d   = '0;
      col_d   = '0;
    end

    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        sr_d[r][0] = sr_q[r][1];
        sr_d[r][1] = new_col[r];
      end
      if (acc_col == COL_LAST) begin
        col_d = '0;
        row_d = acc_row + CW'(1);
      end else begin
        col_d = acc_col + CW'(1);
        row_d = acc_row;
      end
    end

    if (is_win) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = sr_q[r][0];
        win_d[r][1] = sr_q[r][1];
        win_d[r][2] = new_col[r];
      end
    end

    if (is_last) begin
      state_d = S_IDLE;
      row_d   = '0;
      col_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      col_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) win_q[r][c] <= '0;
        for (int c = 0; c < 2; c++) sr_q[r][c] <= '0;
      end
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
      sr_q         <= sr_d;
    end
  end

  // Line storage is deliberately left uninitialised; the counters gate every read that matters.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_mem[idx] <= lb0_mem[idx];
      lb0_mem[idx] <= in_data;
    end
  end

  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q == S_RUN);
  assign win_data   = win_q;

endmodule
